// File: rtl/aud_key_pkg.sv
// Shared definitions for the audio key controller.
// Holds the FSM state encoding, the key-index constants, the command-select
// encoding and the helpers that map keys to commands and commands to
// active-low output vectors.
package aud_key_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    // Key indices, named after the commands they carry in each mode
    localparam logic [1:0] KEY_START_PLAY   = 2'd0;
    localparam logic [1:0] KEY_NEXT_RESTART = 2'd1;
    localparam logic [1:0] KEY_INIT_VOLUP   = 2'd2;
    localparam logic [1:0] KEY_VOLDOWN      = 2'd3;

    // Command select
    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_INIT    = 3'd1,
        CMD_START   = 3'd2,
        CMD_NEXT    = 3'd3,
        CMD_PLAY    = 3'd4,
        CMD_RESTART = 3'd5,
        CMD_VOLUP   = 3'd6,
        CMD_VOLDOWN = 3'd7
    } cmd_e;

    // Bit positions of the commands inside the active-low output vector
    localparam int OUT_INIT    = 0;
    localparam int OUT_START   = 1;
    localparam int OUT_NEXT    = 2;
    localparam int OUT_PLAY    = 3;
    localparam int OUT_RESTART = 4;
    localparam int OUT_VOLUP   = 5;
    localparam int OUT_VOLDOWN = 6;
    localparam int OUT_W       = 7;

    // mode = 1 : control (player stopped), mode = 0 : manipulate (running)
    function automatic cmd_e key_cmd(input logic [1:0] idx, input logic mode);
        cmd_e c;
        c = CMD_NONE;
        if (mode) begin
            case (idx)
                KEY_START_PLAY:   c = CMD_START;
                KEY_NEXT_RESTART: c = CMD_NEXT;
                KEY_INIT_VOLUP:   c = CMD_INIT;
                default:          c = CMD_NONE;
            endcase
        end else begin
            case (idx)
                KEY_START_PLAY:   c = CMD_PLAY;
                KEY_NEXT_RESTART: c = CMD_RESTART;
                KEY_INIT_VOLUP:   c = CMD_VOLUP;
                default:          c = CMD_VOLDOWN;
            endcase
        end
        return c;
    endfunction

    // One-cold decode; CMD_NONE leaves every output released
    function automatic logic [OUT_W-1:0] cmd_decode_n(input cmd_e c);
        logic [OUT_W-1:0] n;
        n = '1;
        case (c)
            CMD_INIT:    n[OUT_INIT]    = 1'b0;
            CMD_START:   n[OUT_START]   = 1'b0;
            CMD_NEXT:    n[OUT_NEXT]    = 1'b0;
            CMD_PLAY:    n[OUT_PLAY]    = 1'b0;
            CMD_RESTART: n[OUT_RESTART] = 1'b0;
            CMD_VOLUP:   n[OUT_VOLUP]   = 1'b0;
            CMD_VOLDOWN: n[OUT_VOLDOWN] = 1'b0;
            default:     n = '1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/aud_key_debounce.sv
// One push-button channel: 2-flop synchronizer, run-length debouncer and
// press (1->0) detector.
// The debounced level follows the synchronized sample once that sample has
// been seen DEB_CNT times in a row; the run counter saturates at DEB_CNT.
// The first settled level after reset is adopted silently, so a key that is
// held through reset never produces a press.
module aud_key_debounce
    import aud_key_pkg::*;
#(
    parameter int unsigned DEB_CNT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);

    localparam int unsigned       CW      = $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0]     RUN_MAX = CW'(DEB_CNT);

    logic          meta_q;
    logic          sync_q;
    logic          prev_q;
    logic          stable_q, stable_d;
    logic          armed_q,  armed_d;
    logic          press_q,  press_d;
    logic [CW-1:0] run_q,    run_d;

    // Run length of identical samples, debounced level and press detect
    always_comb begin
        run_d = run_q;
        if (sync_q != prev_q) begin
            run_d = CW'(1);
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + 1'b1;
        end

        stable_d = stable_q;
        if (run_d == RUN_MAX) begin
            stable_d = sync_q;
        end

        armed_d = armed_q | (run_d == RUN_MAX);
        press_d = armed_q & stable_q & ~stable_d;
    end

    // Synchronizer and debouncer state; levels reset to released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= 1'b1;
            sync_q   <= 1'b1;
            prev_q   <= 1'b1;
            stable_q <= 1'b1;
            armed_q  <= 1'b0;
            press_q  <= 1'b0;
            run_q    <= '0;
        end else begin
            meta_q   <= key_raw;
            sync_q   <= meta_q;
            prev_q   <= sync_q;
            stable_q <= stable_d;
            armed_q  <= armed_d;
            press_q  <= press_d;
            run_q    <= run_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/aud_key_ctrl.sv
// Audio player key controller: four debounced push-buttons are turned into
// single fixed-width active-low command pulses, mapped by player mode.
// Build option AUD_KEY_AUTOINIT_EN: when defined, a boot sequence issues an
// automatic INIT pulse after reset; when undefined the controller starts in
// RUN with BUSY low and INIT only comes from KEY[2] in control mode.
//
// state | meaning
// BOOT  | counting BOOT_DLY clocks after reset release
// INIT  | automatic INIT pulse in progress
// WAIT  | waiting for AUDINF_ISREADY
// RUN   | accepting key presses
module aud_key_ctrl
    import aud_key_pkg::*;
#(
    parameter int unsigned DEB_CNT   = 1000000,
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned BOOT_DLY  = 50000
) (
    input  logic       CLOCK_50,
    input  logic       AUDINF_RESET,
    input  logic [3:0] KEY,
    input  logic       AUDINF_MODE,
    input  logic       AUDINF_ISREADY,
    output logic       AUDINF_INIT,
    output logic       AUDINF_START,
    output logic       AUDINF_NEXT,
    output logic       AUDINF_PLAY,
    output logic       AUDINF_RESTART,
    output logic       AUDINF_VOLUP,
    output logic       AUDINF_VOLDOWN,
    output logic       BUSY
);

    localparam logic [7:0]  PULSE_LEN_C = 8'(PULSE_LEN);
    localparam logic [19:0] BOOT_LAST   = 20'(BOOT_DLY - 1);

`ifdef AUD_KEY_AUTOINIT_EN
    localparam logic [1:0] ST_RST   = ST_BOOT;
    localparam logic       BUSY_RST = 1'b1;
`else
    localparam logic [1:0] ST_RST   = ST_RUN;
    localparam logic       BUSY_RST = 1'b0;
`endif

    logic [3:0]       press;
    logic             key_hit;
    logic [1:0]       key_sel;
    cmd_e             key_cmd_c;

    logic [1:0]       state_q,     state_d;
    logic [19:0]      boot_cnt_q,  boot_cnt_d;
    logic [7:0]       pulse_cnt_q, pulse_cnt_d;
    cmd_e             cmd_sel_q,   cmd_sel_d;
    logic [OUT_W-1:0] cmd_n_q,     cmd_n_d;
    logic             busy_q,      busy_d;

    for (genvar g = 0; g < 4; g++) begin : g_key
        aud_key_debounce #(
            .DEB_CNT (DEB_CNT)
        ) u_deb (
            .clk     (CLOCK_50),
            .rst_n   (AUDINF_RESET),
            .key_raw (KEY[g]),
            .press   (press[g])
        );
    end

    // Lowest key index wins among simultaneous presses
    always_comb begin
        key_hit = |press;
        key_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (press[i]) key_sel = 2'(i);
        end
    end

    // Mode is sampled only here, in the press-detect cycle
    assign key_cmd_c = key_cmd(key_sel, AUDINF_MODE);

    // Sequencer, pulse timer and output decode
    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        cmd_sel_d   = cmd_sel_q;

        if (pulse_cnt_q != '0) pulse_cnt_d = pulse_cnt_q - 1'b1;

        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d     = ST_INIT;
                    boot_cnt_d  = '0;
                    pulse_cnt_d = PULSE_LEN_C;
                    cmd_sel_d   = CMD_INIT;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end
            ST_INIT: begin
                if (pulse_cnt_q <= 8'd1) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (AUDINF_ISREADY) state_d = ST_RUN;
            end
            ST_RUN: begin
                // Presses arriving while a pulse is active are dropped
                if (pulse_cnt_q == '0 && key_hit && key_cmd_c != CMD_NONE) begin
                    pulse_cnt_d = PULSE_LEN_C;
                    cmd_sel_d   = key_cmd_c;
                end
            end
            default: state_d = ST_RST;
        endcase

        if (pulse_cnt_d == '0) cmd_sel_d = CMD_NONE;

        cmd_n_d = cmd_decode_n(cmd_sel_d);
        busy_d  = (state_d != ST_RUN) || (pulse_cnt_d != '0);
    end

    // Registered state; reset releases all outputs at once
    always_ff @(posedge CLOCK_50 or negedge AUDINF_RESET) begin
        if (!AUDINF_RESET) begin
            state_q     <= ST_RST;
            boot_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            cmd_sel_q   <= CMD_NONE;
            cmd_n_q     <= '1;
            busy_q      <= BUSY_RST;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            cmd_sel_q   <= cmd_sel_d;
            cmd_n_q     <= cmd_n_d;
            busy_q      <= busy_d;
        end
    end

    assign AUDINF_INIT    = cmd_n_q[OUT_INIT];
    assign AUDINF_START   = cmd_n_q[OUT_START];
    assign AUDINF_NEXT    = cmd_n_q[OUT_NEXT];
    assign AUDINF_PLAY    = cmd_n_q[OUT_PLAY];
    assign AUDINF_RESTART = cmd_n_q[OUT_RESTART];
    assign AUDINF_VOLUP   = cmd_n_q[OUT_VOLUP];
    assign AUDINF_VOLDOWN = cmd_n_q[OUT_VOLDOWN];
    assign BUSY           = busy_q;

endmodule

// File: tb/tb_aud_key_ctrl.sv
// Bench for aud_key_ctrl with DEB_CNT=8, PULSE_LEN=4, BOOT_DLY=16.
// Expected pulses are queued when keys are driven; a monitor measures every
// observed pulse and compares it with the head of the queue.
module tb_aud_key_ctrl;

    localparam int DEB = 8;
    localparam int PL  = 4;
    localparam int BD  = 16;

    localparam logic [6:0] C_NONE    = 7'h00;
    localparam logic [6:0] C_INIT    = 7'h01;
    localparam logic [6:0] C_START   = 7'h02;
    localparam logic [6:0] C_NEXT    = 7'h04;
    localparam logic [6:0] C_PLAY    = 7'h08;
    localparam logic [6:0] C_RESTART = 7'h10;
    localparam logic [6:0] C_VOLUP   = 7'h20;
    localparam logic [6:0] C_VOLDOWN = 7'h40;

`ifdef AUD_KEY_AUTOINIT_EN
    localparam logic BUSY_AT_RST = 1'b1;
`else
    localparam logic BUSY_AT_RST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key = 4'hF;
    logic       mode = 1'b1;
    logic       isready = 1'b0;
    logic       o_init, o_start, o_next, o_play, o_restart, o_volup, o_voldown;
    logic       busy;
    logic [6:0] lows;

    typedef struct {
        logic [6:0] cmd;
        int         len;
    } exp_t;

    typedef struct {
        logic       mode;
        logic [3:0] keys;
        logic [6:0] cmd;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       vecs[11];
    int         n_checks = 0;
    int         n_fail = 0;
    int         pulses_seen = 0;
    bit         in_pulse = 0;
    logic [6:0] cur_cmd = '0;
    int         cur_len = 0;

    always #5 clk = ~clk;

    aud_key_ctrl #(
        .DEB_CNT   (DEB),
        .PULSE_LEN (PL),
        .BOOT_DLY  (BD)
    ) dut (
        .CLOCK_50       (clk),
        .AUDINF_RESET   (rst_n),
        .KEY            (key),
        .AUDINF_MODE    (mode),
        .AUDINF_ISREADY (isready),
        .AUDINF_INIT    (o_init),
        .AUDINF_START   (o_start),
        .AUDINF_NEXT    (o_next),
        .AUDINF_PLAY    (o_play),
        .AUDINF_RESTART (o_restart),
        .AUDINF_VOLUP   (o_volup),
        .AUDINF_VOLDOWN (o_voldown),
        .BUSY           (busy)
    );

    assign lows = ~{o_voldown, o_volup, o_restart, o_play, o_next, o_start, o_init};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [6:0] cmd);
        exp_t e;
        e.cmd = cmd;
        e.len = PL;
        sb_q.push_back(e);
    endtask

    task automatic end_pulse();
        exp_t e;
        pulses_seen++;
        if (sb_q.size() == 0) begin
            check("unexpected_pulse", 32'(cur_cmd), 32'(C_NONE));
        end else begin
            e = sb_q.pop_front();
            check("pulse_cmd", 32'(cur_cmd), 32'(e.cmd));
            check("pulse_len", 32'(cur_len), 32'(e.len));
        end
    endtask

    // Pulse monitor; a pulse cut short by reset is discarded
    always @(negedge clk) begin
        if (!rst_n) begin
            in_pulse = 0;
        end else if (lows != 7'h00) begin
            check("one_low", 32'($countones(lows)), 32'd1);
            check("busy_in_pulse", 32'(busy), 32'd1);
            if (in_pulse && lows == cur_cmd) begin
                cur_len++;
            end else begin
                if (in_pulse) end_pulse();
                in_pulse = 1;
                cur_cmd  = lows;
                cur_len  = 1;
            end
        end else if (in_pulse) begin
            end_pulse();
            in_pulse = 0;
        end
    end

    task automatic wait_idle(input int max_cyc);
        bit done;
        done = 0;
        for (int t = 0; t < max_cyc && !done; t++) begin
            if (sb_q.size() == 0 && !in_pulse) done = 1;
            else @(negedge clk);
        end
        if (!done) begin
            check("idle_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    // Reset state checks, then release and bring the controller to RUN
    task automatic bring_up();
        int t;
        int p0;
        #1;
        check("rst_outs_high", 32'(lows), 32'd0);
        check("rst_busy", 32'(busy), 32'(BUSY_AT_RST));
        p0 = pulses_seen;
`ifdef AUD_KEY_AUTOINIT_EN
        isready = 1'b0;
        push_exp(C_INIT);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        while (lows == 7'h00 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("init_delay", 32'(t), 32'(BD));
        repeat (PL + 4) @(negedge clk);
        check("busy_in_wait", 32'(busy), 32'd1);
        isready = 1'b1;
        repeat (2) @(negedge clk);
        check("busy_after_wait", 32'(busy), 32'd0);
        check("boot_pulses", 32'(pulses_seen - p0), 32'd1);
`else
        isready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("busy_after_rst", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        check("no_auto_init", 32'(pulses_seen - p0), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int t;

        vecs[0]  = '{1'b1, 4'b0001, C_START};
        vecs[1]  = '{1'b1, 4'b0010, C_NEXT};
        vecs[2]  = '{1'b1, 4'b0100, C_INIT};
        vecs[3]  = '{1'b1, 4'b1000, C_NONE};
        vecs[4]  = '{1'b0, 4'b0001, C_PLAY};
        vecs[5]  = '{1'b0, 4'b0010, C_RESTART};
        vecs[6]  = '{1'b0, 4'b0100, C_VOLUP};
        vecs[7]  = '{1'b0, 4'b1000, C_VOLDOWN};
        vecs[8]  = '{1'b0, 4'b1001, C_PLAY};
        vecs[9]  = '{1'b1, 4'b0110, C_NEXT};
        vecs[10] = '{1'b0, 4'b1100, C_VOLUP};

        repeat (3) @(negedge clk);
        bring_up();
        repeat (20) @(negedge clk);

        // Single presses and simultaneous presses from the table
        foreach (vecs[i]) begin
            p0   = pulses_seen;
            mode = vecs[i].mode;
            @(negedge clk);
            key = ~vecs[i].keys;
            if (vecs[i].cmd != C_NONE) push_exp(vecs[i].cmd);
            repeat (30) @(negedge clk);
            wait_idle(60);
            check($sformatf("vec%0d_pulses", i), 32'(pulses_seen - p0),
                  (vecs[i].cmd != C_NONE) ? 32'd1 : 32'd0);
            key = 4'hF;
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d_busy_idle", i), 32'(busy), 32'd0);
        end

        // Bouncy press held for 100 clocks, bouncy release
        p0   = pulses_seen;
        mode = 1'b0;
        push_exp(C_VOLUP);
        key[2] = 1'b0; @(negedge clk);
        key[2] = 1'b1; @(negedge clk);
        key[2] = 1'b0;
        repeat (100) @(negedge clk);
        check("bounce_hold_pulses", 32'(pulses_seen - p0), 32'd1);
        key[2] = 1'b1; @(negedge clk);
        key[2] = 1'b0; @(negedge clk);
        key[2] = 1'b1;
        repeat (30) @(negedge clk);
        wait_idle(60);
        check("bounce_total_pulses", 32'(pulses_seen - p0), 32'd1);

        // Second press detected while the first pulse is active is dropped
        p0  = pulses_seen;
        key[0] = 1'b0;
        repeat (2) @(negedge clk);
        key[1] = 1'b0;
        push_exp(C_PLAY);
        repeat (30) @(negedge clk);
        wait_idle(60);
        check("busy_drop_pulses", 32'(pulses_seen - p0), 32'd1);
        key = 4'hF;
        repeat (20) @(negedge clk);

        // Mode flips mid-pulse: START keeps its full width, PLAY never fires
        p0   = pulses_seen;
        mode = 1'b1;
        @(negedge clk);
        push_exp(C_START);
        key[0] = 1'b0;
        t = 0;
        while (o_start !== 1'b0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("start_low_seen", 32'(o_start), 32'd0);
        mode = 1'b0;
        repeat (10) @(negedge clk);
        wait_idle(60);
        check("mode_flip_pulses", 32'(pulses_seen - p0), 32'd1);
        key = 4'hF;
        repeat (20) @(negedge clk);

        // Reset during NEXT aborts it; the key stays held through reset
        mode = 1'b1;
        @(negedge clk);
        key[1] = 1'b0;
        t = 0;
        while (o_next !== 1'b0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("next_low_seen", 32'(o_next), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("next_abort", 32'(o_next), 32'd1);
        check("busy_in_rst", 32'(busy), 32'(BUSY_AT_RST));
        repeat (3) @(negedge clk);
        p0 = pulses_seen;
        bring_up();
        repeat (30) @(negedge clk);
        wait_idle(60);
`ifdef AUD_KEY_AUTOINIT_EN
        check("post_rst_pulses", 32'(pulses_seen - p0), 32'd1);
`else
        check("post_rst_pulses", 32'(pulses_seen - p0), 32'd0);
`endif
        key = 4'hF;
        repeat (30) @(negedge clk);
        wait_idle(60);
`ifdef AUD_KEY_AUTOINIT_EN
        check("post_release_pulses", 32'(pulses_seen - p0), 32'd1);
`else
        check("post_release_pulses", 32'(pulses_seen - p0), 32'd0);
`endif

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aud_key_ctrl.md
AUD_KEY_CTRL -- requirements
Module: aud_key_ctrl

Interface
REQ-001 Parameter DEB_CNT, default 1000000, debounce stable-time in clocks (20 ms at 50 MHz).
REQ-002 Parameter PULSE_LEN, default 4, active-low command pulse width in clocks (range 1..255).
REQ-003 Parameter BOOT_DLY, default 50000, clocks from reset release to auto-INIT pulse (range 1..2^20-1).
REQ-004 CLOCK_50  in  1  sole clock, 50 MHz.
REQ-005 AUDINF_RESET  in  1  asynchronous active-low reset.
REQ-006 KEY  in  4  raw push-buttons, active-low, asynchronous to CLOCK_50.
REQ-007 AUDINF_MODE  in  1  player state: 1 = control (stopped), 0 = manipulate (running).
REQ-008 AUDINF_ISREADY  in  1  codec init and in/out engine idle.
REQ-009 AUDINF_INIT, AUDINF_START, AUDINF_NEXT  out  1 each  active-low control commands.
REQ-010 AUDINF_PLAY, AUDINF_RESTART, AUDINF_VOLUP, AUDINF_VOLDOWN  out  1 each  active-low manipulate commands.
REQ-011 BUSY  out  1  high while the boot sequence runs or a command pulse is active.

Function
REQ-012 Each KEY bit SHALL pass a 2-flop synchronizer, then a debouncer that updates its stable level only after DEB_CNT consecutive equal samples.
REQ-013 A press SHALL be the 1->0 transition of a debounced level; exactly one command per press, no auto-repeat while held, nothing on release.
REQ-014 Map with AUDINF_MODE=1: KEY[0]->START, KEY[1]->NEXT, KEY[2]->INIT, KEY[3]->none.
REQ-015 Map with AUDINF_MODE=0: KEY[0]->PLAY, KEY[1]->RESTART, KEY[2]->VOLUP, KEY[3]->VOLDOWN.
REQ-016 Mapping SHALL be sampled in the press-detect cycle and held for the whole pulse; a MODE change mid-pulse SHALL NOT change the active output.
REQ-017 Command output SHALL go low the cycle after press detection and stay low exactly PULSE_LEN cycles, then return high.
REQ-018 At most one command output SHALL be low at any time.
REQ-019 Simultaneous press detections SHALL be resolved lowest KEY index first; the others SHALL be dropped.
REQ-020 Presses detected while BUSY=1 SHALL be dropped, not queued.
REQ-021 FSM states: BOOT (count BOOT_DLY) -> INIT (INIT low PULSE_LEN cycles) -> WAIT (until AUDINF_ISREADY=1) -> RUN.
REQ-022 Key presses SHALL be ignored in BOOT, INIT and WAIT; they SHALL be accepted only in RUN.
REQ-023 Pulse and boot counters SHALL be sized to their parameter ranges and SHALL never wrap; the debounce counter SHALL saturate at DEB_CNT.

Reset
REQ-024 While AUDINF_RESET=0, all command outputs SHALL be 1, BUSY SHALL be 1, FSM SHALL be in BOOT, and all counters SHALL be 0.
REQ-025 Debounced levels SHALL reset to 1 (released) so a key held through reset produces no press.
REQ-026 Reset asserted mid-pulse SHALL force the pulse high asynchronously and abort it, with no resumption after release.

Configuration
REQ-027 Macro AUD_KEY_AUTOINIT_EN defined: the REQ-021 boot sequence SHALL be compiled in.
REQ-028 Macro AUD_KEY_AUTOINIT_EN undefined: the FSM SHALL reset directly into RUN, BUSY SHALL reset to 0, and INIT SHALL come only from KEY[2] in control mode.

Structure
REQ-029 Package aud_key_pkg SHALL hold the FSM state encoding, the key-index constants and the command-select encoding.
REQ-030 One sub-module, aud_key_debounce (synchronizer + debouncer + press detect), SHALL be instantiated four times.

Verification (DEB_CNT=8, PULSE_LEN=4, BOOT_DLY=16, macro defined unless stated)
REQ-031 Release reset, MODE=1, ISREADY=1 -> INIT low exactly 4 clocks starting about 17 clocks after release; BUSY falls once WAIT exits.
REQ-032 In RUN, MODE=0, hold KEY[2] low 100 clocks with 3-clock bounces at the edges -> exactly one 4-clock VOLUP pulse, no further pulse while held.
REQ-033 Press KEY[0] and KEY[3] on the same cycle, MODE=0 -> single PLAY pulse; VOLDOWN stays 1.
REQ-034 MODE=1, press KEY[0], flip MODE to 0 during the pulse -> START pulse of full 4 clocks; PLAY stays 1.
REQ-035 Assert reset during a NEXT pulse -> NEXT=1 immediately; after release the boot sequence restarts and no NEXT pulse is issued.
REQ-036 Macro undefined, release reset, press KEY[2] with MODE=1 -> no INIT until the press, then one 4-clock INIT pulse.
